// File: rtl/fetch_inst_queue.sv
// Fetch-to-predecode decoupling FIFO: takes up to two fetched instructions per cycle,
// compacts sparse valid masks, and presents the two oldest entries in program order.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef BP_GHR_BITS
`define BP_GHR_BITS 8
`endif
`ifndef IF_BATCH_SIZE
`define IF_BATCH_SIZE 2
`endif

module fetch_inst_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_flush,
    input  logic [`INST_WIDTH-1:0]      in_inst_0,
    input  logic [`INST_WIDTH-1:0]      in_inst_1,
    input  logic [`IF_BATCH_SIZE-1:0]   in_inst_valid,
    input  logic                        in_pred_taken_0,
    input  logic                        in_pred_taken_1,
    input  logic [`INST_ADDR_WIDTH-1:0] in_pred_target_0,
    input  logic [`INST_ADDR_WIDTH-1:0] in_pred_target_1,
    input  logic [`BP_GHR_BITS-1:0]     in_pred_hist_0,
    input  logic [`BP_GHR_BITS-1:0]     in_pred_hist_1,
    output logic                        out_fetch_ready,
    input  logic                        in_dec_stall,
    output logic [`INST_WIDTH-1:0]      out_inst_0,
    output logic [`INST_WIDTH-1:0]      out_inst_1,
    output logic [`IF_BATCH_SIZE-1:0]   out_inst_valid,
    output logic                        out_pred_taken_0,
    output logic                        out_pred_taken_1,
    output logic [`INST_ADDR_WIDTH-1:0] out_pred_target_0,
    output logic [`INST_ADDR_WIDTH-1:0] out_pred_target_1,
    output logic [`BP_GHR_BITS-1:0]     out_pred_hist_0,
    output logic [`BP_GHR_BITS-1:0]     out_pred_hist_1,
    output logic [PTR_W:0]              out_count
);

    typedef struct packed {
        logic [`INST_WIDTH-1:0]      inst;
        logic                        pred_taken;
        logic [`INST_ADDR_WIDTH-1:0] pred_target;
        logic [`BP_GHR_BITS-1:0]     pred_hist;
    } entry_t;

    localparam logic [PTR_W:0] FULL_C      = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] READY_MAX_C = (PTR_W+1)'(DEPTH - 2);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   n_enq, n_deq;
    logic             enq_fire;
    entry_t           in_e0, in_e1, head_e, next_e;

    assign in_e0 = '{in_inst_0, in_pred_taken_0, in_pred_target_0, in_pred_hist_0};
    assign in_e1 = '{in_inst_1, in_pred_taken_1, in_pred_target_1, in_pred_hist_1};

    // Readiness looks at the registered count only, so a granted batch always has two free slots.
    assign out_fetch_ready = (count <= READY_MAX_C);
    assign enq_fire        = out_fetch_ready && (|in_inst_valid) && !in_flush;
    assign out_count       = count;

    assign head_e = mem[head];
    assign next_e = mem[head + PTR_W'(1)];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        out_inst_valid    = 2'b00;
        out_inst_0        = '0;
        out_inst_1        = '0;
        out_pred_taken_0  = 1'b0;
        out_pred_taken_1  = 1'b0;
        out_pred_target_0 = '0;
        out_pred_target_1 = '0;
        out_pred_hist_0   = '0;
        out_pred_hist_1   = '0;
        if (count != '0) begin
            out_inst_valid[0] = 1'b1;
            out_inst_0        = head_e.inst;
            out_pred_taken_0  = head_e.pred_taken;
            out_pred_target_0 = head_e.pred_target;
            out_pred_hist_0   = head_e.pred_hist;
        end
        if (count >= (PTR_W+1)'(2)) begin
            out_inst_valid[1] = 1'b1;
            out_inst_1        = next_e.inst;
            out_pred_taken_1  = next_e.pred_taken;
            out_pred_target_1 = next_e.pred_target;
            out_pred_hist_1   = next_e.pred_hist;
        end
    end

    always_comb begin
        n_enq = '0;
        n_deq = '0;
        if (enq_fire)
            n_enq = (in_inst_valid == 2'b11) ? (PTR_W+1)'(2) : (PTR_W+1)'(1);
        if (!in_dec_stall && !in_flush)
            n_deq = (PTR_W+1)'(out_inst_valid[0]) + (PTR_W+1)'(out_inst_valid[1]);
    end

    // NOTE: storage has no reset; head/tail/count alone define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            if (in_inst_valid == 2'b11) begin
                mem[tail]              <= in_e0;
                mem[tail + PTR_W'(1)]  <= in_e1;
            end else begin
                // A lone valid slot is compacted into the next tail position.
                mem[tail] <= in_inst_valid[0] ? in_e0 : in_e1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (in_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + n_deq[PTR_W-1:0];
            tail  <= tail + n_enq[PTR_W-1:0];
            count <= count + n_enq - n_deq;
        end
    end

    count_bound_a: assert property (@(posedge clk) disable iff (!rst_n) count <= FULL_C);

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Directed self-checking bench for fetch_inst_queue: ordering, compaction,
// backpressure, flush, pointer wrap and asynchronous reset.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef BP_GHR_BITS
`define BP_GHR_BITS 8
`endif
`ifndef IF_BATCH_SIZE
`define IF_BATCH_SIZE 2
`endif

module tb_fetch_inst_queue;

    logic                        clk;
    logic                        rst_n;
    logic                        in_flush;
    logic [`INST_WIDTH-1:0]      in_inst_0, in_inst_1;
    logic [`IF_BATCH_SIZE-1:0]   in_inst_valid;
    logic                        in_pred_taken_0, in_pred_taken_1;
    logic [`INST_ADDR_WIDTH-1:0] in_pred_target_0, in_pred_target_1;
    logic [`BP_GHR_BITS-1:0]     in_pred_hist_0, in_pred_hist_1;
    logic                        out_fetch_ready;
    logic                        in_dec_stall;
    logic [`INST_WIDTH-1:0]      out_inst_0, out_inst_1;
    logic [`IF_BATCH_SIZE-1:0]   out_inst_valid;
    logic                        out_pred_taken_0, out_pred_taken_1;
    logic [`INST_ADDR_WIDTH-1:0] out_pred_target_0, out_pred_target_1;
    logic [`BP_GHR_BITS-1:0]     out_pred_hist_0, out_pred_hist_1;
    logic [3:0]                  out_count;

    int checks = 0;
    int errors = 0;

    fetch_inst_queue #(.DEPTH(8), .PTR_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_flush(in_flush),
        .in_inst_0(in_inst_0), .in_inst_1(in_inst_1), .in_inst_valid(in_inst_valid),
        .in_pred_taken_0(in_pred_taken_0), .in_pred_taken_1(in_pred_taken_1),
        .in_pred_target_0(in_pred_target_0), .in_pred_target_1(in_pred_target_1),
        .in_pred_hist_0(in_pred_hist_0), .in_pred_hist_1(in_pred_hist_1),
        .out_fetch_ready(out_fetch_ready), .in_dec_stall(in_dec_stall),
        .out_inst_0(out_inst_0), .out_inst_1(out_inst_1), .out_inst_valid(out_inst_valid),
        .out_pred_taken_0(out_pred_taken_0), .out_pred_taken_1(out_pred_taken_1),
        .out_pred_target_0(out_pred_target_0), .out_pred_target_1(out_pred_target_1),
        .out_pred_hist_0(out_pred_hist_0), .out_pred_hist_1(out_pred_hist_1),
        .out_count(out_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Each instruction id maps to a distinct set of prediction fields.
    function automatic logic [31:0] inst_of(input int id);
        return 32'hA000_0000 + 32'(id);
    endfunction
    function automatic logic [31:0] target_of(input int id);
        return 32'h0040_0000 + 32'(id) * 32'd4;
    endfunction
    function automatic logic [7:0] hist_of(input int id);
        return 8'(id) ^ 8'h5A;
    endfunction
    function automatic logic taken_of(input int id);
        return 1'((id >> 0) & 1);
    endfunction

    task automatic drive(input logic [1:0] v, input int id0, input int id1);
        in_inst_valid    = v;
        in_inst_0        = inst_of(id0);
        in_inst_1        = inst_of(id1);
        in_pred_taken_0  = taken_of(id0);
        in_pred_taken_1  = taken_of(id1);
        in_pred_target_0 = target_of(id0);
        in_pred_target_1 = target_of(id1);
        in_pred_hist_0   = hist_of(id0);
        in_pred_hist_1   = hist_of(id1);
    endtask

    task automatic idle();
        drive(2'b00, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_slots(input string tag, input logic [1:0] ev, input int id0, input int id1);
        check({tag, "_valid"}, 64'(out_inst_valid), 64'(ev));
        check({tag, "_inst0"},   64'(out_inst_0),        ev[0] ? 64'(inst_of(id0))   : 64'd0);
        check({tag, "_taken0"},  64'(out_pred_taken_0),  ev[0] ? 64'(taken_of(id0))  : 64'd0);
        check({tag, "_target0"}, 64'(out_pred_target_0), ev[0] ? 64'(target_of(id0)) : 64'd0);
        check({tag, "_hist0"},   64'(out_pred_hist_0),   ev[0] ? 64'(hist_of(id0))   : 64'd0);
        check({tag, "_inst1"},   64'(out_inst_1),        ev[1] ? 64'(inst_of(id1))   : 64'd0);
        check({tag, "_taken1"},  64'(out_pred_taken_1),  ev[1] ? 64'(taken_of(id1))  : 64'd0);
        check({tag, "_target1"}, 64'(out_pred_target_1), ev[1] ? 64'(target_of(id1)) : 64'd0);
        check({tag, "_hist1"},   64'(out_pred_hist_1),   ev[1] ? 64'(hist_of(id1))   : 64'd0);
    endtask

    task automatic check_state(input string tag, input int cnt, input logic rdy);
        check({tag, "_count"}, 64'(out_count), 64'(cnt));
        check({tag, "_ready"}, 64'(out_fetch_ready), 64'(rdy));
    endtask

    initial begin
        int q[$];
        int next_id;
        logic [1:0] ev;

        rst_n = 1'b0;
        in_flush = 1'b0;
        in_dec_stall = 1'b0;
        idle();
        #12;
        check_state("reset", 0, 1'b1);
        check_slots("reset", 2'b00, 0, 0);
        rst_n = 1'b1;

        // 1: a full batch is presented next cycle, then drained in one cycle.
        drive(2'b11, 1, 2);
        tick();
        idle();
        check_state("t1_loaded", 2, 1'b1);
        check_slots("t1_loaded", 2'b11, 1, 2);
        tick();
        check_state("t1_drained", 0, 1'b1);
        check_slots("t1_drained", 2'b00, 0, 0);

        // 2: sparse masks compact into consecutive entries.
        in_dec_stall = 1'b1;
        drive(2'b10, 99, 3);
        tick();
        check_state("t2_one", 1, 1'b1);
        check_slots("t2_one", 2'b01, 3, 0);
        drive(2'b01, 4, 98);
        tick();
        idle();
        check_state("t2_two", 2, 1'b1);
        check_slots("t2_two", 2'b11, 3, 4);
        in_dec_stall = 1'b0;
        tick();
        check_state("t2_drained", 0, 1'b1);

        // 3: backpressure while downstream is stalled.
        in_dec_stall = 1'b1;
        for (int b = 0; b < 5; b++) begin
            drive(2'b11, 10 + 2 * b, 11 + 2 * b);
            tick();
            case (b)
                2:       check_state("t3_count6", 6, 1'b1);
                3:       check_state("t3_count8", 8, 1'b0);
                4:       check_state("t3_blocked", 8, 1'b0);
                default: check_state("t3_fill", 2 * (b + 1), 1'b1);
            endcase
        end
        idle();
        in_dec_stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_slots("t3_drain", 2'b11, 10 + 2 * k, 11 + 2 * k);
            tick();
        end
        check_state("t3_empty", 0, 1'b1);
        check_slots("t3_empty", 2'b00, 0, 0);

        // 4: fill to seven and drain, three times, so the pointers wrap.
        next_id = 100;
        for (int r = 0; r < 3; r++) begin
            in_dec_stall = 1'b1;
            for (int b = 0; b < 4; b++) begin
                if (b < 3) begin
                    drive(2'b11, next_id, next_id + 1);
                    q.push_back(next_id);
                    q.push_back(next_id + 1);
                    next_id += 2;
                end else begin
                    drive(2'b10, 0, next_id);
                    q.push_back(next_id);
                    next_id += 1;
                end
                tick();
            end
            idle();
            check_state("t4_fill7", 7, 1'b0);
            in_dec_stall = 1'b0;
            for (int k = 0; k < 8 && q.size() > 0; k++) begin
                ev = (q.size() >= 2) ? 2'b11 : 2'b01;
                check_slots("t4_drain", ev, q[0], (q.size() >= 2) ? q[1] : 0);
                check({"t4_count"}, 64'(out_count), 64'(q.size()));
                void'(q.pop_front());
                if (ev == 2'b11) void'(q.pop_front());
                tick();
            end
            check("t4_leftover", 64'(q.size()), 64'd0);
            check_state("t4_empty", 0, 1'b1);
        end

        // 5: flush beats a same-cycle push, even while stalled.
        in_dec_stall = 1'b1;
        drive(2'b11, 200, 201);
        tick();
        drive(2'b11, 202, 203);
        tick();
        drive(2'b01, 204, 0);
        tick();
        check_state("t5_count5", 5, 1'b1);
        drive(2'b11, 205, 206);
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        idle();
        check_state("t5_flushed", 0, 1'b1);
        check_slots("t5_flushed", 2'b00, 0, 0);
        tick();
        check_state("t5_absent", 0, 1'b1);

        // 6: one entry leaves while two arrive in the same cycle.
        drive(2'b01, 50, 0);
        tick();
        check_state("t6_one", 1, 1'b1);
        check_slots("t6_one", 2'b01, 50, 0);
        in_dec_stall = 1'b0;
        drive(2'b11, 51, 52);
        tick();
        idle();
        check_state("t6_swap", 2, 1'b1);
        check_slots("t6_swap", 2'b11, 51, 52);
        tick();
        check_state("t6_empty", 0, 1'b1);

        // Asynchronous reset clears state between clock edges.
        in_dec_stall = 1'b1;
        drive(2'b11, 60, 61);
        tick();
        idle();
        check_state("ar_before", 2, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_state("ar_cleared", 0, 1'b1);
        check_slots("ar_cleared", 2'b00, 0, 0);
        #3;
        rst_n = 1'b1;
        in_dec_stall = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
